// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick and PWM counter,
// per-channel OFF/ON/BLINK/BREATHE. Optional macro LED_GAMMA_EN squares the breathe duty.
module led_pattern_gen #(
  parameter int unsigned CLK_HZ   = 27000000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned PWM_BITS = 8,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [3:0]          cfg_rate,
  output logic                cfg_err,
  output logic                tick,
  output logic [NUM_CH-1:0]   led
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_PEAK = LEVEL_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  mode_e               mode   [NUM_CH];
  logic [3:0]          rate   [NUM_CH];
  logic [15:0]         phase  [NUM_CH];
  logic [PWM_BITS-1:0] level  [NUM_CH];
  logic [PWM_BITS-1:0] duty   [NUM_CH];
  logic [NUM_CH-1:0]   dir_up;
  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH-1:0]   step;
  logic                xfer;
  logic                ch_ok;

  // step[i]: low rate[i] bits of phase are all ones (always true for rate 0)
  always_comb begin
    xfer  = cfg_valid & cfg_ready;
    ch_ok = 32'(cfg_ch) < NUM_CH;
    hit   = '0;
    step  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]  = xfer && ch_ok && (32'(cfg_ch) == i);
      step[i] = &(phase[i] | ~((16'd1 << rate[i]) - 16'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      tick      <= 1'b0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      tick      <= (presc == PRE_LAST);
      presc     <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      cfg_ready <= 1'b1;
      cfg_err   <= xfer && !ch_ok;
    end
  end

  // A config hit takes priority over the tick, discarding that tick's advance
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_up <= '1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode[i]  <= MODE_OFF;
        rate[i]  <= '0;
        phase[i] <= '0;
        level[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          mode[i]   <= mode_e'(cfg_mode);
          rate[i]   <= cfg_rate;
          phase[i]  <= '0;
          level[i]  <= '0;
          dir_up[i] <= 1'b1;
        end else if (tick) begin
          phase[i] <= phase[i] + 16'd1;
          if (mode[i] == MODE_BREATHE && step[i]) begin
            if (dir_up[i]) begin
              level[i] <= level[i] + 1'b1;
              if (level[i] == LEVEL_PEAK) dir_up[i] <= 1'b0;
            end else begin
              level[i] <= level[i] - 1'b1;
              if (level[i] == LEVEL_ONE) dir_up[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef LED_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] l);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst) duty[i] <= '0;
      else     duty[i] <= gamma(level[i]);
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) duty[i] = level[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        unique case (mode[i])
          MODE_OFF:     led[i] <= 1'b0;
          MODE_ON:      led[i] <= 1'b1;
          MODE_BLINK:   led[i] <= phase[i][rate[i]];
          MODE_BREATHE: led[i] <= (pwm_cnt < duty[i]);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (DIV=10, 3 channels, 4-bit PWM):
// constant vector table, directed sequences and random config traffic against a tick-count model.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_rate = '0;
  logic       cfg_err;
  logic       tick;
  logic [2:0] led;

  led_pattern_gen #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .NUM_CH  (3),
    .PWM_BITS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_rate (cfg_rate),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .led      (led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: cycles since reset release, and per channel the ticks seen since its last config
  int         m_c;
  bit         m_tick, m_ready, m_err;
  logic [2:0] m_led;
  int         m_mode [3];
  int         m_rate [3];
  int         m_t    [3];

  function automatic int tri_level(input int s);
    int m;
    m = s % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic bit exp_led(input int i, input int pwm);
    case (m_mode[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'((m_t[i] >> m_rate[i]) & 1);
      default: return pwm < tri_level(m_t[i] >> m_rate[i]);
    endcase
  endfunction

  task automatic model_step(input bit r, input bit v, input int ch, input int md, input int rt);
    bit pre_tick;
    bit acc;
    if (r) begin
      m_c = 0; m_tick = 0; m_ready = 0; m_err = 0; m_led = '0;
      for (int i = 0; i < 3; i++) begin m_mode[i] = 0; m_rate[i] = 0; m_t[i] = 0; end
      return;
    end
    pre_tick = m_tick;
    for (int i = 0; i < 3; i++) m_led[i] = exp_led(i, m_c % 16);
    acc = v && m_ready;
    for (int i = 0; i < 3; i++) begin
      if (acc && ch == i) begin m_mode[i] = md; m_rate[i] = rt; m_t[i] = 0; end
      else if (pre_tick) m_t[i]++;
    end
    m_err   = acc && (ch >= 3);
    m_ready = 1;
    m_c++;
    m_tick  = (m_c % 10 == 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input int ch, input int md, input int rt);
    @(negedge clk);
    rst = r; cfg_valid = v; cfg_ch = 2'(ch); cfg_mode = 2'(md); cfg_rate = 4'(rt);
    @(posedge clk);
    model_step(r, v, ch, md, rt);
    #1;
    check("led",       32'(led),       32'(m_led));
    check("tick",      32'(tick),      32'(m_tick));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("cfg_err",   32'(cfg_err),   32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit       rst;
    bit       valid;
    int       ch;
    int       mode;
    int       rate;
    logic [2:0] led;
    bit       tick;
    bit       ready;
    bit       err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Row k is cycle k after reset release; expectations are hand-derived constants
    tbl[0]  = '{1, 0, 0, 0, 0, 3'b000, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 3'b000, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 3'b000, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 3'b001, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 3'b000, 0, 1, 0};
    tbl[5]  = '{0, 1, 3, 1, 0, 3'b000, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 3'b000, 0, 1, 0};
    tbl[7]  = '{0, 1, 1, 1, 0, 3'b000, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 3'b010, 0, 1, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 3'b010, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 3'b000, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 3'b000, 0, 1, 0};

    for (int k = 0; k < 12; k++) begin
      cycle(tbl[k].rst, tbl[k].valid, tbl[k].ch, tbl[k].mode, tbl[k].rate);
      check("tbl_led",   32'(led),       32'(tbl[k].led));
      check("tbl_tick",  32'(tick),      32'(tbl[k].tick));
      check("tbl_ready", 32'(cfg_ready), 32'(tbl[k].ready));
      check("tbl_err",   32'(cfg_err),   32'(tbl[k].err));
    end

    // Idle after reset, then blink, back-to-back ON/OFF, breathe, bad channel
    cycle(1, 0, 0, 0, 0);
    idle(100);
    cycle(0, 1, 1, 2, 2);
    idle(200);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    idle(5);
    cycle(0, 1, 2, 3, 0);
    idle(650);
    cycle(0, 1, 3, 1, 0);
    idle(3);

    // Config landing on a tick cycle must leave phase at 0
    for (int k = 0; k < 20 && !m_tick; k++) idle(1);
    if (!m_tick) begin
      n_bad++;
      $display("FAIL tick_wait: actual=0 required=1");
    end
    cycle(0, 1, 1, 2, 0);
    idle(15);

    // Reset mid-breathe, with a config attempt held during reset
    cycle(0, 1, 2, 3, 0);
    idle(60);
    cycle(1, 1, 0, 1, 0);
    cycle(0, 1, 1, 1, 0);
    idle(20);

    for (int k = 0; k < 4000; k++) begin
      bit r, v;
      int ch, md, rt;
      r  = ($urandom_range(0, 599) == 0);
      v  = ($urandom_range(0, 29) == 0);
      ch = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      rt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      cycle(r, v, ch, md, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
